// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline encodings and the execute-register payload type.
// Imported by every pipe stage so icode/stat/register-ID constants stay in one place.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SADR    = 3'd2;
    localparam logic [2:0] SINS    = 3'd3;
    localparam logic [2:0] SHLT    = 3'd4;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } e_reg_t;

    // A bubble is a harmless nop that writes no register and reads none.
    function automatic e_reg_t e_bubble();
        e_reg_t b;
        b.stat  = SAOK;
        b.icode = INOP;
        b.ifun  = 4'h0;
        b.valC  = 64'h0;
        b.valA  = 64'h0;
        b.valB  = 64'h0;
        b.dstE  = RNONE;
        b.dstM  = RNONE;
        b.srcA  = RNONE;
        b.srcB  = RNONE;
        return b;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline hazard control: load-use, branch mispredict and return handling.
// Purely combinational; drives stall/bubble requests for fetch, decode and execute.
module pipe_ctrl
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] E_icode,
    input  logic [3:0] M_icode,
    input  logic [3:0] E_dstM,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic       e_Cnd,
    output logic       F_stall,
    output logic       D_stall,
    output logic       D_bubble,
    output logic       E_bubble
);

    logic load_use_s;
    logic mispredict_s;
    logic ret_pending_s;

    // Hazard detection terms; a bubble in E (INOP, dstM=RNONE) clears both E-based terms.
    always_comb begin
        load_use_s    = 1'b0;
        mispredict_s  = 1'b0;
        ret_pending_s = 1'b0;
        if (((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
            ((E_dstM == d_srcA) || (E_dstM == d_srcB))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
        if ((E_icode == IJXX) && (e_Cnd == 1'b0)) begin
            mispredict_s = 1'b1;
        end else begin
            mispredict_s = 1'b0;
        end
        if ((D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET)) begin
            ret_pending_s = 1'b1;
        end else begin
            ret_pending_s = 1'b0;
        end
    end

    // Stall/bubble requests; load-use suppresses the ret bubble so the stalled decode keeps its instruction.
    always_comb begin
        F_stall  = load_use_s | ret_pending_s;
        D_stall  = load_use_s;
        D_bubble = mispredict_s | (ret_pending_s & ~load_use_s);
        E_bubble = mispredict_s | load_use_s;
    end

endmodule

// File: rtl/execute_reg.sv
// Y86-64 execute pipeline register with integrated hazard control.
// Captures decode outputs every edge, or loads a nop bubble on load-use/mispredict.
module execute_reg
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  D_stat,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_ifun,
    input  logic [63:0] D_valC,
    input  logic [63:0] d_valA,
    input  logic [63:0] d_valB,
    input  logic [3:0]  d_dstE,
    input  logic [3:0]  d_dstM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic        e_Cnd,
    input  logic [3:0]  M_icode,
    output logic [2:0]  E_stat,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble
);

    e_reg_t e_q;
    e_reg_t e_d;
    e_reg_t d_in_s;
    logic   e_bubble_s;

    pipe_ctrl u_pipe_ctrl (
        .D_icode  (D_icode),
        .E_icode  (e_q.icode),
        .M_icode  (M_icode),
        .E_dstM   (e_q.dstM),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .e_Cnd    (e_Cnd),
        .F_stall  (F_stall),
        .D_stall  (D_stall),
        .D_bubble (D_bubble),
        .E_bubble (e_bubble_s)
    );

    // Gather the decode-stage fields into the register payload.
    always_comb begin
        d_in_s.stat  = D_stat;
        d_in_s.icode = D_icode;
        d_in_s.ifun  = D_ifun;
        d_in_s.valC  = D_valC;
        d_in_s.valA  = d_valA;
        d_in_s.valB  = d_valB;
        d_in_s.dstE  = d_dstE;
        d_in_s.dstM  = d_dstM;
        d_in_s.srcA  = d_srcA;
        d_in_s.srcB  = d_srcB;
    end

    // Next-state select: E never stalls, it either captures or bubbles.
    always_comb begin
        e_d = d_in_s;
        if (e_bubble_s) begin
            e_d = e_bubble();
        end else begin
            e_d = d_in_s;
        end
    end

    // Execute register; reset forces the bubble immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= e_bubble();
        end else begin
            e_q <= e_d;
        end
    end

    assign E_stat  = e_q.stat;
    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_valC  = e_q.valC;
    assign E_valA  = e_q.valA;
    assign E_valB  = e_q.valB;
    assign E_dstE  = e_q.dstE;
    assign E_dstM  = e_q.dstM;
    assign E_srcA  = e_q.srcA;
    assign E_srcB  = e_q.srcB;

endmodule

// File: tb/tb_execute_reg.sv
// Scoreboard bench for execute_reg: directed rows push expected stall/bubble and next-E values,
// a monitor pops and compares them each cycle.
module tb_execute_reg;

    logic        clk;
    logic        rst;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode;
    logic [3:0]  D_ifun;
    logic [63:0] D_valC;
    logic [63:0] d_valA;
    logic [63:0] d_valB;
    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic        e_Cnd;
    logic [3:0]  M_icode;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [63:0] E_valC;
    logic [63:0] E_valA;
    logic [63:0] E_valB;
    logic [3:0]  E_dstE;
    logic [3:0]  E_dstM;
    logic [3:0]  E_srcA;
    logic [3:0]  E_srcB;
    logic        F_stall;
    logic        D_stall;
    logic        D_bubble;

    execute_reg dut (
        .clk(clk), .rst(rst),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_valC(D_valC),
        .d_valA(d_valA), .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
        .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_srcA(E_srcA), .E_srcB(E_srcB),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble)
    );

    typedef struct {
        int           id;
        logic [2:0]   ctl;
        logic [218:0] e;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [218:0] mk_e(input logic [2:0] s, input logic [3:0] i, input logic [3:0] f,
                                          input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] de, input logic [3:0] dm,
                                          input logic [3:0] sa, input logic [3:0] sb);
        return {s, i, f, c, a, b, de, dm, sa, sb};
    endfunction

    function automatic logic [218:0] e_now();
        return {E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB};
    endfunction

    task automatic check(input string nm, input int id, input logic [218:0] act, input logic [218:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Drive one decode-stage vector and record what must appear this cycle and after the next edge.
    task automatic step(input int id, input logic [218:0] din, input logic [3:0] m_ic, input logic cnd,
                        input logic [2:0] exp_ctl, input logic [218:0] exp_e);
        exp_t x;
        @(posedge clk);
        #1;
        {D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB} = din;
        M_icode = m_ic;
        e_Cnd   = cnd;
        x.id  = id;
        x.ctl = exp_ctl;
        x.e   = exp_e;
        sb_q.push_back(x);
    endtask

    // Monitor: combinational outputs mid-cycle, registered E just after the following edge.
    initial begin
        exp_t cur;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                cur = sb_q[0];
                check("ctl{F_stall,D_stall,D_bubble}", cur.id, {216'h0, F_stall, D_stall, D_bubble}, {216'h0, cur.ctl});
                @(posedge clk);
                #1;
                check("E_reg", cur.id, e_now(), cur.e);
                void'(sb_q.pop_front());
            end
        end
    end

    localparam logic [3:0] F = 4'hF;

    initial begin
        logic [218:0] bub;
        logic [218:0] nop_in;
        bub    = mk_e(3'd1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, F, F, F, F);
        nop_in = bub;

        rst = 1'b1;
        {D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB} =
            mk_e(3'd1, 4'h9, 4'h0, 64'h0, 64'h0, 64'h0, F, F, 4'h4, 4'h4);
        M_icode = 4'h1;
        e_Cnd   = 1'b1;
        #2;
        check("reset_E", 0, e_now(), bub);
        check("reset_ctl_ret", 0, {216'h0, F_stall, D_stall, D_bubble}, {216'h0, 3'b101});
        D_icode = 4'h1;
        #1;
        check("reset_ctl_idle", 0, {216'h0, F_stall, D_stall, D_bubble}, {216'h0, 3'b000});
        @(posedge clk);
        #1;
        check("reset_hold_E", 0, e_now(), bub);
        #2;
        rst = 1'b0;

        // plain flow
        step(1, mk_e(3'd1, 4'h6, 4'h0, 64'h0, 64'h5, 64'h7, 4'h3, F, 4'h1, 4'h2), 4'h1, 1'b1, 3'b000,
             mk_e(3'd1, 4'h6, 4'h0, 64'h0, 64'h5, 64'h7, 4'h3, F, 4'h1, 4'h2));
        // mrmovq into %rdx (reg 2)
        step(2, mk_e(3'd1, 4'h5, 4'h0, 64'h8, 64'h0, 64'h100, F, 4'h2, F, 4'h4), 4'h1, 1'b1, 3'b000,
             mk_e(3'd1, 4'h5, 4'h0, 64'h8, 64'h0, 64'h100, F, 4'h2, F, 4'h4));
        // dependent opq -> load-use
        step(3, mk_e(3'd1, 4'h6, 4'h1, 64'h0, 64'h11, 64'h22, 4'h5, F, 4'h2, 4'h5), 4'h1, 1'b1, 3'b110, bub);
        // held decode re-presented; bubble in E cleared the hazard
        step(4, mk_e(3'd1, 4'h6, 4'h1, 64'h0, 64'h11, 64'h22, 4'h5, F, 4'h2, 4'h5), 4'h1, 1'b1, 3'b000,
             mk_e(3'd1, 4'h6, 4'h1, 64'h0, 64'h11, 64'h22, 4'h5, F, 4'h2, 4'h5));
        // jxx enters E
        step(5, mk_e(3'd1, 4'h7, 4'h3, 64'h40, 64'h0, 64'h0, F, F, F, F), 4'h1, 1'b1, 3'b000,
             mk_e(3'd1, 4'h7, 4'h3, 64'h40, 64'h0, 64'h0, F, F, F, F));
        // not taken -> mispredict
        step(6, mk_e(3'd1, 4'h6, 4'h0, 64'h0, 64'h1, 64'h2, 4'h6, F, 4'h3, 4'h4), 4'h1, 1'b0, 3'b001, bub);
        // second jxx; e_Cnd=0 irrelevant with bubble in E
        step(7, mk_e(3'd1, 4'h7, 4'h3, 64'h80, 64'h0, 64'h0, F, F, F, F), 4'h1, 1'b0, 3'b000,
             mk_e(3'd1, 4'h7, 4'h3, 64'h80, 64'h0, 64'h0, F, F, F, F));
        // taken -> no bubble
        step(8, mk_e(3'd1, 4'h6, 4'h2, 64'h0, 64'h3, 64'h4, 4'h7, F, 4'h8, 4'h9), 4'h1, 1'b1, 3'b000,
             mk_e(3'd1, 4'h6, 4'h2, 64'h0, 64'h3, 64'h4, 4'h7, F, 4'h8, 4'h9));
        // ret in D, then E, then M
        step(9, mk_e(3'd1, 4'h9, 4'h0, 64'h0, 64'h200, 64'h200, 4'h4, F, 4'h4, 4'h4), 4'h1, 1'b1, 3'b101,
             mk_e(3'd1, 4'h9, 4'h0, 64'h0, 64'h200, 64'h200, 4'h4, F, 4'h4, 4'h4));
        step(10, nop_in, 4'h1, 1'b1, 3'b101, bub);
        step(11, nop_in, 4'h9, 1'b1, 3'b101, bub);
        step(12, nop_in, 4'h1, 1'b1, 3'b000, bub);
        // load-use together with ret pending in M
        step(13, mk_e(3'd1, 4'h5, 4'h0, 64'h10, 64'h0, 64'h300, F, 4'h3, F, 4'h4), 4'h1, 1'b1, 3'b000,
             mk_e(3'd1, 4'h5, 4'h0, 64'h10, 64'h0, 64'h300, F, 4'h3, F, 4'h4));
        step(14, mk_e(3'd1, 4'h6, 4'h0, 64'h0, 64'h1, 64'h2, 4'h6, F, 4'h3, 4'h6), 4'h9, 1'b1, 3'b110, bub);
        // non-AOK stat passes through unmodified
        step(15, mk_e(3'd4, 4'h0, 4'h0, 64'h0, 64'h0, 64'h0, F, F, F, F), 4'h1, 1'b1, 3'b000,
             mk_e(3'd4, 4'h0, 4'h0, 64'h0, 64'h0, 64'h0, F, F, F, F));
        // mrmovq with dstM=RNONE, then consumer with RNONE sources: no load-use
        step(16, mk_e(3'd1, 4'h5, 4'h0, 64'h0, 64'h0, 64'h0, F, F, F, 4'h4), 4'h1, 1'b1, 3'b000,
             mk_e(3'd1, 4'h5, 4'h0, 64'h0, 64'h0, 64'h0, F, F, F, 4'h4));
        step(17, mk_e(3'd1, 4'h6, 4'h0, 64'h0, 64'h0, 64'h0, 4'h2, F, F, F), 4'h1, 1'b1, 3'b000,
             mk_e(3'd1, 4'h6, 4'h0, 64'h0, 64'h0, 64'h0, 4'h2, F, F, F));

        // asynchronous reset between edges while E holds icode 6
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_E", 18, e_now(), bub);
        {D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB} = nop_in;
        M_icode = 4'h9;
        #1;
        check("rst_ctl_ret_M", 18, {216'h0, F_stall, D_stall, D_bubble}, {216'h0, 3'b101});
        M_icode = 4'h1;
        @(posedge clk);
        #1;
        check("rst_hold_E", 18, e_now(), bub);
        #2;
        rst = 1'b0;
        step(19, mk_e(3'd1, 4'h6, 4'h0, 64'h0, 64'h9, 64'hA, 4'h1, F, 4'h2, 4'h3), 4'h1, 1'b1, 3'b000,
             mk_e(3'd1, 4'h6, 4'h0, 64'h0, 64'h9, 64'hA, 4'h1, F, 4'h2, 4'h3));

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
